// File: rtl/password_programmer_if.sv
// Keypad-side inputs and memory-write/status outputs of the password programmer.
interface password_programmer_if #(
    parameter int unsigned ADDR_W = 2
);
    logic [3:0]        PassInp;
    logic              LoadPassNumber;
    logic              ProgEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [3:0]        MemData;
    logic              MemWe;
    logic              Busy;
    logic              Done;
    logic              Err;

    modport master (
        output PassInp, LoadPassNumber, ProgEn,
        input  MemAddr, MemData, MemWe, Busy, Done, Err
    );

    modport slave (
        input  PassInp, LoadPassNumber, ProgEn,
        output MemAddr, MemData, MemWe, Busy, Done, Err
    );
endinterface

// File: rtl/password_programmer.sv
// Collects a password and its confirmation from the keypad, then writes the
// digits into the password RAM one at a time with a fixed hold after each pulse.
module password_programmer #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    password_programmer_if.slave bus
);
    localparam int unsigned       WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DIGITS - 1);
    localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CONFIRM, S_CHECK, S_WRITE, S_HOLD, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [DIGITS-1:0][3:0] nbuf_q, nbuf_d, cbuf_q, cbuf_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d, idx_q, idx_d, addr_q, addr_d;
    logic [ADDR_W-1:0]      idx_inc_c;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [3:0]             data_q, data_d;
    logic                   ld_q;
    logic                   we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                   strobe_c;

    // Rising edge of the strobe; ld_q resets low so a strobe held through reset counts once.
    assign strobe_c  = bus.LoadPassNumber & ~ld_q;
    assign idx_inc_c = idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            nbuf_q  <= '0;
            cbuf_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ld_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nbuf_q  <= nbuf_d;
            cbuf_q  <= cbuf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ld_q    <= bus.LoadPassNumber;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are set on the transition into the state that owns them.
    always_comb begin
        state_d = state_q;
        nbuf_d  = nbuf_q;
        cbuf_d  = cbuf_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ProgEn) begin
                    state_d = S_ENTRY;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_ENTRY, S_CONFIRM: begin
                if (!bus.ProgEn) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (strobe_c) begin
                    if (state_q == S_ENTRY) nbuf_d[cnt_q] = bus.PassInp;
                    else                    cbuf_d[cnt_q] = bus.PassInp;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_ENTRY) ? S_CONFIRM : S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (nbuf_q == cbuf_q) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = nbuf_q[0];
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_HOLD;
                wcnt_d  = '0;
            end
            S_HOLD: begin
                if (wcnt_q == WLAST) begin
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        idx_d   = idx_inc_c;
                        we_d    = 1'b1;
                        addr_d  = idx_inc_c;
                        data_d  = nbuf_q[idx_inc_c];
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                data_d  = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.MemAddr = addr_q;
    assign bus.MemData = data_q;
    assign bus.MemWe   = we_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Err     = err_q;
endmodule
